// File: rtl/mux_stream_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Selection modes and the select-width helper live here.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } outState_e;

  // Width able to index n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Round-robin arbiter: owns the last-grant pointer and picks the first
// requester after it, wrapping around the channel list.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int  N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [W-1:0] gnt,
  output logic         gnt_vld
);

  logic [W-1:0] lastGrant_q, lastGrant_d;
  int           idx;

  // Reset points at the top channel so channel 0 wins the first scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastGrant_q <= W'(N - 1);
    else        lastGrant_q <= lastGrant_d;
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (advance && gnt_vld) lastGrant_d = gnt;
  end

  // Scan descending so the nearest requester after the pointer is written last.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(lastGrant_q) + k) % N;
      if (req[idx]) begin
        gnt     = W'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel stream multiplexer with one registered output stage, using either
// a fixed external select or round-robin arbitration.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int  N_CH   = 4,
  parameter int  DATA_W = 8,
  parameter int  MODE   = MODE_FIXED,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  outState_e         state_q, state_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [SEL_W-1:0]  outCh_q, outCh_d;
  logic [SEL_W-1:0]  gnt;
  logic              gntVld;
  logic              loadEn;
  logic              transfer;
  logic [DATA_W-1:0] selData;

  assign loadEn   = (state_q == EMPTY) || out_ready;
  assign transfer = loadEn && gntVld && rst_n;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unusedSel;
      assign unusedSel = ^sel;
      rr_arbiter #(.N(N_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_vld (gntVld)
      );
    end else begin : g_fixed
      // A select beyond the last channel matches no channel and never grants.
      always_comb begin
        gntVld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) gntVld = 1'b1;
        end
      end
      assign gnt = sel;
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    selData  = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = transfer && (gnt == SEL_W'(i));
      if (gnt == SEL_W'(i)) selData = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Draining without a new load empties the stage but keeps data/channel.
  always_comb begin
    state_d   = state_q;
    outData_d = outData_q;
    outCh_d   = outCh_q;
    if (transfer) begin
      state_d   = FULL;
      outData_d = selData;
      outCh_d   = gnt;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      outData_q <= '0;
      outCh_q   <= '0;
    end else begin
      state_q   <= state_d;
      outData_q <= outData_d;
      outCh_q   <= outCh_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = outData_q;
  assign out_ch    = outCh_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench: three DUT instances (fixed N=4, round-robin N=4,
// fixed N=3) checked every cycle against a behavioural model plus literals.
module tb_mux_stream_rr;

  typedef struct {
    bit v;
    int data;
    int ch;
    int last;
  } model_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  selA, selB, selC;
  logic [3:0]  validA, validB, readyA, readyB;
  logic [2:0]  validC, readyC;
  logic [31:0] dataA, dataB;
  logic [23:0] dataC;
  logic        outValidA, outValidB, outValidC;
  logic        outReadyA, outReadyB, outReadyC;
  logic [7:0]  outDataA, outDataB, outDataC;
  logic [1:0]  outChA, outChB, outChC;

  model_t mA, mB, mC;
  int     rrSeq[6]   = '{0, 1, 2, 3, 0, 1};
  int     skipSeq[4] = '{3, 1, 3, 1};

  always #5 clk = ~clk;

  mux_stream_rr #(.N_CH(4), .DATA_W(8), .MODE(0)) dutA (
    .clk(clk), .rst_n(rst_n), .sel(selA), .in_valid(validA), .in_data(dataA),
    .in_ready(readyA), .out_valid(outValidA), .out_data(outDataA),
    .out_ch(outChA), .out_ready(outReadyA));

  mux_stream_rr #(.N_CH(4), .DATA_W(8), .MODE(1)) dutB (
    .clk(clk), .rst_n(rst_n), .sel(selB), .in_valid(validB), .in_data(dataB),
    .in_ready(readyB), .out_valid(outValidB), .out_data(outDataB),
    .out_ch(outChB), .out_ready(outReadyB));

  mux_stream_rr #(.N_CH(3), .DATA_W(8), .MODE(0)) dutC (
    .clk(clk), .rst_n(rst_n), .sel(selC), .in_valid(validC), .in_data(dataC),
    .in_ready(readyC), .out_valid(outValidC), .out_data(outDataC),
    .out_ch(outChC), .out_ready(outReadyC));

  // Winning channel for this cycle, or -1 when nothing may transfer.
  function automatic int modelGrant(int mode, int n, int sel, logic [15:0] valid, int last);
    if (mode == 0) return (sel < n && valid[sel]) ? sel : -1;
    for (int k = 1; k <= n; k++) begin
      if (valid[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  function automatic model_t modelReset(int n);
    model_t m;
    m.v = 1'b0; m.data = 0; m.ch = 0; m.last = n - 1;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, int mode, int n, int sel,
                                       logic [15:0] valid, logic [63:0] data, bit outReady);
    int g = modelGrant(mode, n, sel, valid, m.last);
    if ((!m.v || outReady) && g >= 0) begin
      m.v    = 1'b1;
      m.data = int'((data >> (g * 8)) & 64'hFF);
      m.ch   = g;
      m.last = g;
    end else if (outReady) begin
      m.v = 1'b0;
    end
    return m;
  endfunction

  function automatic int modelReady(model_t m, int mode, int n, int sel,
                                    logic [15:0] valid, bit outReady, bit rstn);
    int g = modelGrant(mode, n, sel, valid, m.last);
    if (!rstn) return 0;
    if ((!m.v || outReady) && g >= 0) return 1 << g;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(input string name, input model_t m, input logic v,
                             input logic [7:0] d, input logic [1:0] ch,
                             input logic [3:0] rdy, input int expRdy);
    checkOutput({name, "_valid"}, 64'(v), 64'(m.v));
    checkOutput({name, "_data"}, 64'(d), 64'(m.data));
    checkOutput({name, "_ch"}, 64'(ch), 64'(m.ch));
    checkOutput({name, "_ready"}, 64'(rdy), 64'(expRdy));
  endtask

  // Step the clock and let everything settle just past the edge.
  task automatic applyStimulus(input int nCycles);
    repeat (nCycles) @(posedge clk);
    #1;
  endtask

  // Model tracks the DUT registers; reset acts on it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA = modelReset(4); mB = modelReset(4); mC = modelReset(3);
    end else begin
      mA = modelStep(mA, 0, 4, int'(selA), 16'(validA), 64'(dataA), outReadyA);
      mB = modelStep(mB, 1, 4, int'(selB), 16'(validB), 64'(dataB), outReadyB);
      mC = modelStep(mC, 0, 3, int'(selC), 16'(validC), 64'(dataC), outReadyC);
    end
  end

  always @(negedge clk) begin
    compareInst("A", mA, outValidA, outDataA, outChA, readyA,
                modelReady(mA, 0, 4, int'(selA), 16'(validA), outReadyA, rst_n));
    compareInst("B", mB, outValidB, outDataB, outChB, readyB,
                modelReady(mB, 1, 4, int'(selB), 16'(validB), outReadyB, rst_n));
    compareInst("C", mC, outValidC, outDataC, outChC, 4'(readyC),
                modelReady(mC, 0, 3, int'(selC), 16'(validC), outReadyC, rst_n));
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mA = modelReset(4); mB = modelReset(4); mC = modelReset(3);
    rst_n = 1'b0;
    selA = 2'd0; selB = 2'd0; selC = 2'd0;
    validA = 4'b1111; validB = 4'b1111; validC = 3'b111;
    dataA = 32'h44_33_22_11; dataB = 32'h13_12_11_10; dataC = 24'h22_21_20;
    outReadyA = 1'b1; outReadyB = 1'b1; outReadyC = 1'b1;

    applyStimulus(2);
    checkOutput("rst_valid", 64'(outValidB), 64'd0);
    checkOutput("rst_data", 64'(outDataB), 64'd0);
    checkOutput("rst_ch", 64'(outChB), 64'd0);
    checkOutput("rst_ready", 64'(readyB), 64'd0);

    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      checkOutput("rr_seq", 64'(outChB), 64'(rrSeq[k]));
      checkOutput("rr_beat", 64'(outValidB), 64'd1);
    end
    checkOutput("rr_first_data", 64'(outDataB), 64'h11);

    validB = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("rr_skip", 64'(outChB), 64'(skipSeq[k]));
    end
    validB = 4'b0000;

    selA = 2'd2; dataA = 32'h44_A5_22_11; validA = 4'b0100;
    #1;
    checkOutput("fix_ready", 64'(readyA), 64'b0100);
    applyStimulus(1);
    checkOutput("fix_valid", 64'(outValidA), 64'd1);
    checkOutput("fix_data", 64'(outDataA), 64'hA5);
    checkOutput("fix_ch", 64'(outChA), 64'd2);

    selA = 2'd1; dataA = 32'h00_00_3C_00; validA = 4'b0010;
    applyStimulus(1);
    outReadyA = 1'b0;
    for (int k = 0; k < 5; k++) begin
      selA = 2'(k); validA = 4'(k * 5 + 3); dataA = $urandom;
      #1;
      checkOutput("bp_ready", 64'(readyA), 64'd0);
      applyStimulus(1);
      checkOutput("bp_data", 64'(outDataA), 64'h3C);
      checkOutput("bp_ch", 64'(outChA), 64'd1);
    end
    selA = 2'd3; dataA = 32'h77_00_00_00; validA = 4'b1000; outReadyA = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(readyA), 64'b1000);
    applyStimulus(1);
    checkOutput("bp_release_data", 64'(outDataA), 64'h77);
    checkOutput("bp_release_ch", 64'(outChA), 64'd3);
    validA = 4'b0000; outReadyA = 1'b0;

    selC = 2'd3;
    applyStimulus(1);
    checkOutput("c_oob_valid", 64'(outValidC), 64'd0);
    applyStimulus(2);
    checkOutput("c_oob_valid2", 64'(outValidC), 64'd0);
    checkOutput("c_oob_ready", 64'(readyC), 64'd0);

    applyStimulus(1);
    checkOutput("held_valid", 64'(outValidA), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(outValidA), 64'd0);
    checkOutput("async_rst_data", 64'(outDataA), 64'd0);
    applyStimulus(1);
    rst_n = 1'b1;
    outReadyA = 1'b1;
    applyStimulus(2);
    checkOutput("post_rst_idle", 64'(outValidA), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
